dac_frame_sequencer: RTL and testbench
======================================

# dac_frame_sequencer

Serial-frame controller that sequences updates of the DAC reference code and data code. It deframes a start-marked serial stream from a top-level input pin, routes the payload to the VREF or DATA shadow register, waits a programmable settle interval, then commits the shadow to the output register with a one-cycle load strobe. It sits between the tile's `ui_in` pins and the DAC drive outputs (`uo_out`/`uio_out`).

## Interface
- `VREF_W`, default 4: width of the reference-code register.
- `DATA_W`, default 8: width of the data-code register.
- `SETTLE_CYC`, default 4: idle cycles between the last payload bit and the commit; 0 is legal.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sen`  in  1  frame qualifier; a frame is valid only while high.
- `sdi`  in  1  serial data, MSB first, sampled together with `sen`.
- `vref_out`  out  VREF_W  committed reference code.
- `data_out`  out  DATA_W  committed data code.
- `load_strobe`  out  1  one-cycle pulse in the cycle after any commit.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse for an aborted or rejected frame.

## Operation
- Frame format: start bit (1), select bit (0 = VREF, 1 = DATA), then payload MSB first (VREF_W or DATA_W bits). With parity enabled, one parity bit follows.
- States: IDLE, SEL, PAYLOAD, [PARITY], SETTLE, COMMIT, WAIT_LOW.
- IDLE: a bit with `sen`=1 and `sdi`=1 moves the FSM to SEL. A bit with `sen`=1 and `sdi`=0 is ignored.
- SEL: latches the target and clears the bit counter, then moves to PAYLOAD.
- PAYLOAD: shifts `sdi` into the target shadow register. After the last bit the FSM moves to SETTLE, or to PARITY when parity is enabled.
- SETTLE: counts SETTLE_CYC cycles and ignores `sen`/`sdi`.
- COMMIT: copies the shadow to the selected output only; the other output is unchanged. Next state is WAIT_LOW if `sen`=1, else IDLE.
- WAIT_LOW: ignores all bits until `sen`=0, then returns to IDLE. Back-to-back frames therefore need `sen` low for at least one cycle.
- Abort: `sen`=0 in SEL, PAYLOAD or PARITY pulses `frame_err`, discards the shadow, leaves outputs unchanged and returns to IDLE.
- Reset, including mid-frame: state IDLE; `vref_out`=0, `data_out`=0, shadows 0, counters 0; `load_strobe`=0, `busy`=0, `frame_err`=0.

## Timing
- Edge 0 samples the start bit, edge 1 the select bit, and edges 2..W+1 the payload (W = target width).
- With SETTLE_CYC=S, the selected output changes on edge W+2+S.
- `load_strobe` is high for exactly the cycle following that edge.
- `busy` rises after edge 0 and falls after the edge that leaves COMMIT or WAIT_LOW.
- Parity adds one edge: outputs change on edge W+3+S.
- `frame_err` is high for the cycle following the offending edge.
- SETTLE_CYC=0: COMMIT directly follows the last payload (or parity) bit.
- The settle counter is wide enough for SETTLE_CYC and never wraps.

## Configuration
- `DAC_SEQ_PARITY_EN` defined:
  - a parity bit follows the payload; total ones over select + payload + parity must be even;
  - on mismatch: `frame_err` pulses, no commit, no `load_strobe`, FSM goes to WAIT_LOW (or IDLE if `sen`=0).
- Undefined: no parity state or bit; the frame ends after the payload.

## Test plan
- Reset values: assert `rst_n`=0 mid-frame (after 5 DATA bits) -> outputs 0, `busy`=0 immediately and asynchronously. After release, a full DATA 0x3C frame commits normally.
- DATA commit (SETTLE_CYC=4, no parity): `sen`=1, bits 1,1,10100101 on edges 0..9.
  - `data_out`=0xA5 on edge 14, `load_strobe` one cycle.
  - `vref_out` stays 0.
- VREF commit, with `data_out` holding 0xA5: bits 1,0,1011.
  - `vref_out`=0xB on edge 10.
  - `data_out` stays 0xA5.
- Abort: drop `sen` after 3 payload bits -> `frame_err` one cycle, no `load_strobe`, outputs unchanged, `busy`=0 next cycle.
- `sen` held high after a complete frame: a further 1,1,0xFF bit stream is ignored (WAIT_LOW), and `data_out` is unchanged. Dropping `sen` for one cycle, then sending 1,1,0x0F, gives `data_out`=0x0F.
- `DAC_SEQ_PARITY_EN`: DATA 0xA5 (sel=1, four payload ones -> five ones).
  - Parity bit 1 -> commit on edge 15.
  - Parity bit 0 -> `frame_err`, `data_out` unchanged.

Source files
------------

// File: rtl/dac_frame_sequencer.sv
// Deframes a start-marked serial stream into VREF/DATA shadows and commits after a settle gap.
// Latency: selected output updates W+2+SETTLE_CYC edges after the start bit (one more with parity).
// No backpressure: sen/sdi are sampled every cycle; DAC_SEQ_PARITY_EN adds an even-parity bit.
module dac_frame_sequencer #(
  parameter int VREF_W     = 4,
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sen,
  input  logic              sdi,
  output logic [VREF_W-1:0] vref_out,
  output logic [DATA_W-1:0] data_out,
  output logic              load_strobe,
  output logic              busy,
  output logic              frame_err
);

  localparam int MAXW = (VREF_W > DATA_W) ? VREF_W : DATA_W;
  localparam int BCW  = $clog2(MAXW + 1);
  // Sized so the counter can hold SETTLE_CYC-1 without wrapping; stays 1 bit when SETTLE_CYC is 0.
  localparam int SCW  = $clog2(SETTLE_CYC + 2);

  localparam logic [BCW-1:0] VREF_LAST   = BCW'(VREF_W - 1);
  localparam logic [BCW-1:0] DATA_LAST   = BCW'(DATA_W - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    PAYLOAD,
`ifdef DAC_SEQ_PARITY_EN
    PARITY,
`endif
    SETTLE,
    COMMIT,
    WAIT_LOW
  } state_t;

  // With no settle interval the commit follows the last frame bit directly.
  localparam state_t AFTER_FRAME = (SETTLE_CYC == 0) ? COMMIT : SETTLE;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]      settle_cnt_q, settle_cnt_d;
  logic [VREF_W-1:0]   vref_sh_q, vref_sh_d;
  logic [DATA_W-1:0]   data_sh_q, data_sh_d;
  logic [VREF_W-1:0]   vref_q, vref_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
`ifdef DAC_SEQ_PARITY_EN
  logic                par_q, par_d;
`endif

  // Next-state, shadow shifting and commit logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    bit_cnt_d    = bit_cnt_q;
    settle_cnt_d = settle_cnt_q;
    vref_sh_d    = vref_sh_q;
    data_sh_d    = data_sh_q;
    vref_d       = vref_q;
    data_d       = data_q;
    load_d       = 1'b0;
    err_d        = 1'b0;
`ifdef DAC_SEQ_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (sen && sdi) begin
          state_d = SEL;
        end
      end

      SEL: begin
        if (!sen) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          sel_d     = sdi;
          bit_cnt_d = '0;
          if (sdi) data_sh_d = '0;
          else     vref_sh_d = '0;
`ifdef DAC_SEQ_PARITY_EN
          par_d = sdi;
`endif
          state_d = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (!sen) begin
          err_d   = 1'b1;
          state_d = IDLE;
          if (sel_q) data_sh_d = '0;
          else       vref_sh_d = '0;
        end else begin
          bit_cnt_d    = bit_cnt_q + 1'b1;
          settle_cnt_d = '0;
`ifdef DAC_SEQ_PARITY_EN
          par_d = par_q ^ sdi;
`endif
          if (sel_q) data_sh_d = {data_sh_q[DATA_W-2:0], sdi};
          else       vref_sh_d = {vref_sh_q[VREF_W-2:0], sdi};
          if ((sel_q && bit_cnt_q == DATA_LAST) || (!sel_q && bit_cnt_q == VREF_LAST)) begin
`ifdef DAC_SEQ_PARITY_EN
            state_d = PARITY;
`else
            state_d = AFTER_FRAME;
`endif
          end
        end
      end

`ifdef DAC_SEQ_PARITY_EN
      PARITY: begin
        if (!sen) begin
          err_d   = 1'b1;
          state_d = IDLE;
          if (sel_q) data_sh_d = '0;
          else       vref_sh_d = '0;
        end else if (par_q ^ sdi) begin
          // Odd total of ones: reject the frame and wait for the qualifier to drop.
          err_d   = 1'b1;
          state_d = WAIT_LOW;
          if (sel_q) data_sh_d = '0;
          else       vref_sh_d = '0;
        end else begin
          settle_cnt_d = '0;
          state_d      = AFTER_FRAME;
        end
      end
`endif

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = COMMIT;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      COMMIT: begin
        load_d = 1'b1;
        if (sel_q) data_d = data_sh_q;
        else       vref_d = vref_sh_q;
        state_d = sen ? WAIT_LOW : IDLE;
      end

      WAIT_LOW: begin
        if (!sen) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      vref_sh_q    <= '0;
      data_sh_q    <= '0;
      vref_q       <= '0;
      data_q       <= '0;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef DAC_SEQ_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      vref_sh_q    <= vref_sh_d;
      data_sh_q    <= data_sh_d;
      vref_q       <= vref_d;
      data_q       <= data_d;
      load_q       <= load_d;
      err_q        <= err_d;
`ifdef DAC_SEQ_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign vref_out    = vref_q;
  assign data_out    = data_q;
  assign load_strobe = load_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench for dac_frame_sequencer (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Parity-specific vectors are included only when DAC_SEQ_PARITY_EN is defined.
module tb_dac_frame_sequencer;

  localparam int VW = 4;
  localparam int DW = 8;
  localparam int S  = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          sen   = 1'b0;
  logic          sdi   = 1'b0;
  logic [VW-1:0] vref_out;
  logic [DW-1:0] data_out;
  logic          load_strobe;
  logic          busy;
  logic          frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int s0;

  dac_frame_sequencer #(.VREF_W(VW), .DATA_W(DW), .SETTLE_CYC(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sen         (sen),
    .sdi         (sdi),
    .vref_out    (vref_out),
    .data_out    (data_out),
    .load_strobe (load_strobe),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_strobe === 1'b1) strobe_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One bit per cycle: set on the falling edge, return just after the rising edge.
  task automatic drive(input logic s, input logic d);
    @(negedge clk);
    sen = s;
    sdi = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic s);
    repeat (n) drive(s, 1'b0);
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] pl, input int w);
    drive(1'b1, 1'b1);
    drive(1'b1, sel);
    for (int i = w - 1; i >= 0; i--) drive(1'b1, pl[i]);
`ifdef DAC_SEQ_PARITY_EN
    drive(1'b1, sel ^ (^pl));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_vref", 32'(vref_out), 32'h0);
    chk_eq("rst_data", 32'(data_out), 32'h0);
    chk_eq("rst_busy", 32'(busy), 32'h0);
    chk_eq("rst_strobe", 32'(load_strobe), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // DATA commit 0xA5: busy after the start bit, commit S+1 edges after the frame
    drive(1'b1, 1'b1);
    chk_eq("busy_after_start", 32'(busy), 32'h1);
    drive(1'b1, 1'b1);
    begin
      logic [7:0] a5;
      a5 = 8'hA5;
      for (int i = 7; i >= 0; i--) drive(1'b1, a5[i]);
`ifdef DAC_SEQ_PARITY_EN
      drive(1'b1, 1'b1);
`endif
    end
    idle(S, 1'b0);
    chk_eq("data_pre_commit", 32'(data_out), 32'h0);
    chk_eq("strobe_pre_commit", 32'(load_strobe), 32'h0);
    idle(1, 1'b0);
    chk_eq("data_commit", 32'(data_out), 32'hA5);
    chk_eq("data_strobe", 32'(load_strobe), 32'h1);
    chk_eq("data_vref_kept", 32'(vref_out), 32'h0);
    chk_eq("data_busy_low", 32'(busy), 32'h0);
    idle(1, 1'b0);
    chk_eq("data_strobe_1cyc", 32'(load_strobe), 32'h0);

    // VREF commit 0xB, DATA untouched
    send_frame(1'b0, 8'h0B, VW);
    idle(S, 1'b0);
    chk_eq("vref_pre_commit", 32'(vref_out), 32'h0);
    idle(1, 1'b0);
    chk_eq("vref_commit", 32'(vref_out), 32'hB);
    chk_eq("vref_strobe", 32'(load_strobe), 32'h1);
    chk_eq("vref_data_kept", 32'(data_out), 32'hA5);
    idle(1, 1'b0);

    // Abort after 3 payload bits
    s0 = strobe_cnt;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk_eq("abort_err", 32'(frame_err), 32'h1);
    chk_eq("abort_busy", 32'(busy), 32'h0);
    idle(S + 3, 1'b0);
    chk_eq("abort_err_1cyc", 32'(frame_err), 32'h0);
    chk_eq("abort_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    chk_eq("abort_data_kept", 32'(data_out), 32'hA5);
    chk_eq("abort_vref_kept", 32'(vref_out), 32'hB);

    // sen held high across a commit: the next stream is ignored until sen drops
    send_frame(1'b1, 8'h5A, DW);
    idle(S, 1'b1);
    drive(1'b1, 1'b0);
    chk_eq("wl_commit", 32'(data_out), 32'h5A);
    chk_eq("wl_busy", 32'(busy), 32'h1);
    drive(1'b1, 1'b0);
    s0 = strobe_cnt;
    send_frame(1'b1, 8'hFF, DW);
    idle(S + 2, 1'b1);
    chk_eq("wl_ignored_data", 32'(data_out), 32'h5A);
    chk_eq("wl_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    chk_eq("wl_still_busy", 32'(busy), 32'h1);
    drive(1'b0, 1'b0);
    chk_eq("wl_released", 32'(busy), 32'h0);
    send_frame(1'b1, 8'h0F, DW);
    idle(S + 1, 1'b0);
    chk_eq("wl_next_frame", 32'(data_out), 32'h0F);

    // Asynchronous reset mid-frame after 5 DATA bits
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_data", 32'(data_out), 32'h0);
    chk_eq("mid_rst_vref", 32'(vref_out), 32'h0);
    chk_eq("mid_rst_busy", 32'(busy), 32'h0);
    chk_eq("mid_rst_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    sen = 1'b0;
    rst_n = 1'b1;
    send_frame(1'b1, 8'h3C, DW);
    idle(S + 1, 1'b0);
    chk_eq("post_rst_data", 32'(data_out), 32'h3C);
    chk_eq("post_rst_strobe", 32'(load_strobe), 32'h1);
    idle(1, 1'b0);

`ifdef DAC_SEQ_PARITY_EN
    // Good parity: commit on edge 15
    begin
      logic [7:0] pa;
      pa = 8'hA5;
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) drive(1'b1, pa[i]);
      drive(1'b1, 1'b1);
      idle(S, 1'b0);
      chk_eq("par_pre_commit", 32'(data_out), 32'h3C);
      idle(1, 1'b0);
      chk_eq("par_commit", 32'(data_out), 32'hA5);
      chk_eq("par_strobe", 32'(load_strobe), 32'h1);
      idle(1, 1'b0);

      // Bad parity: rejected, no commit
      pa = 8'h3C;
      s0 = strobe_cnt;
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) drive(1'b1, pa[i]);
      drive(1'b1, 1'b0);
      chk_eq("par_bad_err", 32'(frame_err), 32'h1);
      idle(S + 2, 1'b0);
      chk_eq("par_bad_data", 32'(data_out), 32'hA5);
      chk_eq("par_bad_no_strobe", 32'(strobe_cnt - s0), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
